mdu_seq: RTL

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO registers; mult/div occupy a fixed cycle count.
// busy high for MULT_CYCLES/DIV_CYCLES after acceptance; starts while busy are dropped.
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state, stateNxt;
  logic [CW-1:0] cnt, cntNxt;
  logic [31:0]   aLat, bLat, aNxt, bNxt, hiNxt, loNxt;
  logic          sgnLat, sgnNxt;

  logic [63:0] product;
  logic        negA, negB;
  logic [31:0] absA, absB, uQuot, uRem, quot, rem;

  // Sign-extending to 64 bits makes the low 64 product bits correct for both flavours.
  assign product = {{32{sgnLat & aLat[31]}}, aLat} * {{32{sgnLat & bLat[31]}}, bLat};

  // Signed division via magnitudes: avoids the 0x80000000 / -1 overflow corner.
  assign negA  = sgnLat & aLat[31];
  assign negB  = sgnLat & bLat[31];
  assign absA  = negA ? (32'd0 - aLat) : aLat;
  assign absB  = negB ? (32'd0 - bLat) : bLat;
  assign uQuot = (bLat == 32'd0) ? 32'd0 : absA / absB;
  assign uRem  = (bLat == 32'd0) ? 32'd0 : absA % absB;
  assign quot  = (negA ^ negB) ? (32'd0 - uQuot) : uQuot;
  assign rem   = negA ? (32'd0 - uRem) : uRem;

  assign busy = (state != IDLE);

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    aNxt     = aLat;
    bNxt     = bLat;
    sgnNxt   = sgnLat;
    hiNxt    = hi;
    loNxt    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdOp)
            3'b000, 3'b001: begin
              aNxt     = A;
              bNxt     = B;
              sgnNxt   = ~mdOp[0];
              cntNxt   = CW'(MULT_CYCLES);
              stateNxt = MUL;
            end
            3'b010, 3'b011: begin
              aNxt     = A;
              bNxt     = B;
              sgnNxt   = ~mdOp[0];
              cntNxt   = CW'(DIV_CYCLES);
              stateNxt = DIV;
            end
            3'b100:  hiNxt = A;
            3'b101:  loNxt = A;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt == CW'(1)) begin
          hiNxt    = product[63:32];
          loNxt    = product[31:0];
          cntNxt   = '0;
          stateNxt = IDLE;
        end else begin
          cntNxt = cnt - CW'(1);
        end
      end
      DIV: begin
        if (cnt == CW'(1)) begin
          // A zero divisor burns the full latency but leaves HI/LO untouched.
          if (bLat != 32'd0) begin
            hiNxt = rem;
            loNxt = quot;
          end
          cntNxt   = '0;
          stateNxt = IDLE;
        end else begin
          cntNxt = cnt - CW'(1);
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      aLat   <= '0;
      bLat   <= '0;
      sgnLat <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= stateNxt;
      cnt    <= cntNxt;
      aLat   <= aNxt;
      bLat   <= bNxt;
      sgnLat <= sgnNxt;
      hi     <= hiNxt;
      lo     <= loNxt;
    end
  end

endmodule
